// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand/result handshake bundle for the iterative binary32 multiplier.
//   master : operand issuer / result consumer side (drives in_valid, a, b, out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, result, flag_*)
// Signals:
//   in_valid/in_ready   operand handshake, a/b are binary32 operands
//   out_valid/out_ready result handshake, result is the binary32 product
//   flag_invalid        NaN operand or inf*0
//   flag_overflow       product saturated to infinity
//   flag_underflow      product flushed to zero
interface fp_mul_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            flag_invalid;
  logic            flag_overflow;
  logic            flag_underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flag_invalid, flag_overflow, flag_underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flag_invalid, flag_overflow, flag_underflow
  );
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754 binary32 multiplier, one shift-add mantissa step per clock.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fp_mul_seq_if.slave (operand handshake in, result + flags handshake out)
// Build option:
//   FP_MUL_RNE_EN defined   -> round to nearest even (guard/sticky/lsb)
//   FP_MUL_RNE_EN undefined -> truncation (round toward zero)
// Subnormal operands are treated as signed zero; subnormal results flush to zero.
module fp_mul_seq #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 24
) (
  input logic          clk,
  input logic          rst,
  fp_mul_seq_if.slave  bus
);

  localparam int unsigned AccW = 2 * MUL_BITS;
  localparam logic [4:0]  LastCnt = 5'(MUL_BITS - 1);

  typedef enum logic [2:0] {StIdle, StSpecial, StMul, StNorm, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              inv_q, inv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Exponent zero covers both true zero and subnormals (flushed).
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
  endfunction

  logic [MUL_BITS-1:0] mant_a, mant_b;
  logic [AccW-1:0]     addend;

  assign mant_a = {1'b1, a_q[22:0]};
  assign mant_b = {1'b1, b_q[22:0]};
  assign addend = {{MUL_BITS{1'b0}}, mant_a} << cnt_q;

  // Normalise and round the finished product.
  logic [22:0]       norm_frac;
  logic signed [9:0] norm_exp;
  logic              norm_ovf;
  logic              norm_unf;
`ifdef FP_MUL_RNE_EN
  logic        norm_guard;
  logic        norm_sticky;
  logic        round_up;
  logic [23:0] frac_rnd;
`endif

  always_comb begin
    norm_frac = 23'd0;
    norm_exp  = exp_q;
`ifdef FP_MUL_RNE_EN
    norm_guard  = 1'b0;
    norm_sticky = 1'b0;
    round_up    = 1'b0;
    frac_rnd    = 24'd0;
`endif
    // Product of two [1,2) mantissas lies in [1,4): bit 47 set means [2,4).
    if (acc_q[47]) begin
      norm_frac = acc_q[46:24];
      norm_exp  = exp_q + 10'sd1;
`ifdef FP_MUL_RNE_EN
      norm_guard  = acc_q[23];
      norm_sticky = |acc_q[22:0];
`endif
    end else begin
      norm_frac = acc_q[45:23];
`ifdef FP_MUL_RNE_EN
      norm_guard  = acc_q[22];
      norm_sticky = |acc_q[21:0];
`endif
    end
`ifdef FP_MUL_RNE_EN
    round_up = norm_guard & (norm_sticky | norm_frac[0]);
    frac_rnd = {1'b0, norm_frac} + {23'd0, round_up};
    // Carry-out means mantissa rolled over to 2.0; fraction bits are already zero.
    if (frac_rnd[23]) begin
      norm_exp = norm_exp + 10'sd1;
    end
    norm_frac = frac_rnd[22:0];
`endif
    norm_ovf = norm_exp >= 10'sd255;
    norm_unf = norm_exp <= 10'sd0;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    inv_d       = inv_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d    = bus.a;
          b_d    = bus.b;
          sign_d = bus.a[31] ^ bus.b[31];
          exp_d  = $signed({2'b00, bus.a[30:23]}) + $signed({2'b00, bus.b[30:23]}) - 10'sd127;
          acc_d  = '0;
          cnt_d  = 5'd0;
          state_d = (is_special(bus.a) || is_special(bus.b)) ? StSpecial : StMul;
        end
      end

      StSpecial: begin
        if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_zero(b_q)) ||
            (is_zero(a_q) && is_inf(b_q))) begin
          result_d = 32'h7FC0_0000;
          inv_d    = 1'b1;
        end else if (is_inf(a_q) || is_inf(b_q)) begin
          result_d = {sign_q, 8'hFF, 23'd0};
        end else begin
          result_d = {sign_q, 31'd0};
        end
        state_d = StDone;
      end

      StMul: begin
        if (mant_b[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastCnt) begin
          state_d = StNorm;
        end
      end

      StNorm: begin
        if (norm_ovf) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (norm_unf) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, norm_exp[7:0], norm_frac};
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end

      StDone: begin
        // Special results arrive here with out_valid low and present one edge later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          inv_d       = 1'b0;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      inv_q       <= inv_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.in_ready       = (state_q == StIdle) && !rst;
  assign bus.out_valid      = out_valid_q;
  assign bus.result         = result_q;
  assign bus.flag_invalid   = inv_q;
  assign bus.flag_overflow  = ovf_q;
  assign bus.flag_underflow = unf_q;

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Iterative IEEE-754 single-precision multiplier with valid/ready handshakes on both sides.
- Uses one shift-add mantissa step per clock.
- It is the inverse companion of the Newton-Raphson FP divider: it recomputes A = Q*B for divide-result checking and serves as the area-lean multiply for non-timing-critical paths.
- Sits between an operand-issuing controller (input side) and a result consumer (output side).

Parameters:
- XLEN, 32, operand/result width. Only 32 (binary32) is supported.
- MUL_BITS, 24, mantissa multiplier bits processed per operation, one per cycle. Fixed to 24.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  XLEN  multiplicand, IEEE binary32
- b  input  XLEN  multiplier, IEEE binary32
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  product, IEEE binary32
- flag_invalid  output  1  NaN operand or inf*0
- flag_overflow  output  1  result saturated to infinity
- flag_underflow  output  1  result flushed to zero

Behaviour:
- Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, all flags=0. in_ready=0 while rst is high, 1 after release.
- States: IDLE, SPECIAL, MUL, NORM, DONE.
- in_ready = (state==IDLE) && !rst. No acceptance in any other state.
- IDLE: on an edge with in_valid&&in_ready, register a, b, sign=a[31]^b[31].
  - Classify operands; subnormal inputs are treated as signed zero.
  - Go to SPECIAL if either operand is NaN, inf or zero; otherwise go to MUL with count=0.
- SPECIAL, one edge, then DONE. Priority order:
  - NaN operand, or inf*0: result=0x7FC00000, flag_invalid=1.
  - inf*x: {sign,0xFF,0}.
  - zero*x: {sign,31'b0}.
- MUL: 48-bit accumulator; each edge adds (mantA<<count) if bit[count] of mantB is set. count increments 0..23. On the edge where count==23, go to NORM.
- Exponent rule: e = ea + eb - 127, computed in a 10-bit signed register.
- NORM, one edge:
  - If product bit47=1, shift right 1 and e+=1.
  - Take 23 fraction bits, a guard bit, and a sticky (OR of the remaining bits); round per feature.
  - A rounding carry-out renormalises (e+=1).
  - e>=255: result={sign,0xFF,0}, flag_overflow=1.
  - e<=0: result={sign,31'b0}, flag_underflow=1 (no subnormal output).
  - Otherwise result={sign,e[7:0],frac}.
- DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready. On that edge: out_valid=0, flags clear, go to IDLE.
- Latency, counting edges after the accept edge:
  - Normal operands: out_valid rises on edge 25 (24 MUL + 1 NORM).
  - Special operands: out_valid rises on edge 2 (SPECIAL, then DONE).
- Throughput: one operation in flight. A new accept is possible on the edge after the output handshake, at the earliest.
- Flags are registered with result and are mutually exclusive.
- Async reset mid-operation aborts immediately: out_valid drops, partial product is discarded, nothing is emitted.
- in_valid held during DONE is ignored; the operands must be re-presented in IDLE.

Optional Feature:
- Macro: FP_MUL_RNE_EN.
- Defined: round-to-nearest-even using guard, sticky and LSB; round up when guard&&(sticky||lsb).
- Undefined: truncation (round toward zero). Guard and sticky logic are not synthesized; results can differ by 1 ulp.

Test Plan:
- a=0x40000000 (2.0), b=0x40400000 (3.0) -> result=0x40C00000, flags 0, out_valid on edge 25 after accept.
- a=0x3FC00000, b=0xBF000000 -> result=0xBF400000. Then a=0x3FC00001, b=0x3FC00001 -> 0x40100002 with FP_MUL_RNE_EN, 0x40100001 without.
- a=0x7F800000, b=0x00000000 -> result=0x7FC00000, flag_invalid=1, out_valid on edge 2. a=0xFF800000, b=0x40000000 -> 0xFF800000, flags 0.
- a=0x7F000000, b=0x40000000 -> 0x7F800000, flag_overflow=1. a=0x00800000, b=0x3F000000 -> 0x00000000, flag_underflow=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0, a second in_valid is ignored. out_ready=1 -> in_ready=1 on the next cycle.
- Assert rst at MUL count=10 -> out_valid=0 and result=0 asynchronously. After release, in_ready=1, and a fresh 2.0*3.0 completes correctly at edge 25.
